operand_loader: RTL and testbench
=================================

# operand_loader

Sequential front end for the 4-bit add/subtract datapath on the lab board. It debounces two raw push-buttons and steps a small state machine through operand entry. Switch values are latched into operand A, then operand B plus the operation select. The block then drives the datapath's `input_a`, `input_b`, `select` and `enable` inputs so the result appears on the LEDs.

## Interface
- `WIDTH`, 4: operand width; matches datapath operand width.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz). Must be ≥1.

- `clk` in 1: board clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in WIDTH: operand switches; sampled only on an accepted press.
- `sw_op` in 1: operation switch; 1 = subtract, 0 = add.
- `btn_next` in 1: raw push-button, active-high, asynchronous to `clk`, may bounce.
- `btn_clr` in 1: raw push-button, active-high, asynchronous, may bounce.
- `input_a` out WIDTH: operand A to datapath.
- `input_b` out WIDTH: operand B to datapath.
- `select` out 1: datapath op select (1 = A−B, 0 = A+B).
- `enable` out 1: datapath enable; 0 makes datapath show all-ones.
- `state_led` out 2: current state encoding, for board LEDs.

## Operation
- **Input conditioning.** Each button has a 2-flop synchronizer, then a debounce counter and a registered debounced level `db`.
  - The counter increments each cycle the synchronized level differs from `db`.
  - It clears to 0 on any cycle the two are equal.
  - When the levels still differ with the count at `DEBOUNCE_CYCLES-1`, `db` takes the new level and the count clears.
- **Press pulse.** `press = db & ~db_q`, where `db_q` is `db` delayed one cycle. This gives one cycle per accepted press; release never generates a pulse.
- **State machine** (`state_led` value shown):
  - `S_A` (00): on `next` press, `input_a <= sw`; go to `S_B`.
  - `S_B` (01): on `next` press, `input_b <= sw`, `select <= sw_op`, `enable <= 1`; go to `S_RUN`.
  - `S_RUN` (10): on `next` press, `enable <= 0`; go to `S_A`. Operand handling depends on configuration.
  - Encoding 11 is unused; if reached, return to `S_A` on the next edge with the same outputs as a clear.
- **Clear.** A `clr` press in any state sets `input_a = 0`, `input_b = 0`, `select = 0`, `enable = 0` and goes to `S_A`.
  - If `clr` and `next` presses occur in the same cycle, `clr` wins.
- **Output stability.** `sw` and `sw_op` changes outside a press cycle have no effect. Outputs are registered and glitch-free.
- **Reset values.** `input_a = 0`, `input_b = 0`, `select = 0`, `enable = 0`, `state_led = 00`. Synchronizers, debounce counters, `db` and `db_q` are all 0.
  - Reset assertion mid-entry or mid-debounce takes effect immediately, with no clock needed.
  - A button held through reset release is first accepted as a press `DEBOUNCE_CYCLES+2` edges after release, and is counted as a press.

## Timing
- Edge 1 is the first rising edge that samples a raw button high, and the raw level stays high. Then:
  - `db` rises at edge `DEBOUNCE_CYCLES+2`.
  - `press` is high for exactly the following cycle.
  - Outputs and state update at edge `DEBOUNCE_CYCLES+3`.
- A raw high shorter than `DEBOUNCE_CYCLES` synchronized cycles is rejected. Release uses the same debounce rule, so a new press requires a fully debounced release first.
- The datapath sees new operands and `enable` in the same cycle, so there is no cycle where `enable = 1` with stale operands.
- Throughput: at most one state step per debounced press.

## Configuration
- `OPERAND_LOADER_AUTO_CLEAR_EN`
  - Defined: the `S_RUN` → `S_A` transition also zeroes `input_a`, `input_b` and `select`.
  - Undefined: that transition clears only `enable`; operands and `select` keep their values until overwritten by the next entry.
  - Clear and reset behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- **Reset mid-entry.** Reach `S_B` with `input_a = 3`, then pulse `rst_n` low between clock edges → all outputs 0 and `state_led = 00` immediately; the next press loads `input_a`.
- **Full sequence.** `sw = 3`, hold `next` until accepted, release; `sw = 5`, `sw_op = 1`, hold `next` until accepted → `input_a = 3`, `input_b = 5`, `select = 1`, `enable = 1`, `state_led = 10`. Each update lands exactly at edge 7 after the raw high.
- **Bounce rejection.** Toggle `btn_next` every 2 cycles for 20 cycles, then hold low → no state change. Then a clean 3-cycle high → no change; a clean 4-cycle high → exactly one step.
- **Long hold.** Hold `btn_next` for 100 cycles in `S_A` → exactly one step to `S_B`; release gives no step.
- **Simultaneous buttons.** In `S_B` with `input_a = 3`, raise `clr` and `next` on the same edge → `S_A`, `input_a = 0`, `enable = 0`.
- **Run exit.** From `S_RUN` (3, 5, sub), press `next` → `enable = 0`, `state_led = 00`. With the macro undefined, `input_a = 3`, `input_b = 5`, `select = 1` remain; with it defined, all three are 0.

Source files
------------

// File: rtl/operand_loader.sv
// Operand entry front end for the 4-bit add/subtract datapath: debounced buttons step A -> B -> RUN.
// Build option: define OPERAND_LOADER_AUTO_CLEAR_EN to zero the operands and select when leaving RUN.

module operand_loader_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] count;
  logic          db;
  logic          db_q;

  // Any disagreement streak shorter than DEBOUNCE_CYCLES is discarded; release obeys the same rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      count <= '0;
      db    <= 1'b0;
      db_q  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      db_q <= db;
      if (sync[1] == db) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        db    <= sync[1];
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign press = db & ~db_q;

endmodule

module operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_op,
  input  logic             btn_next,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] input_a,
  output logic [WIDTH-1:0] input_b,
  output logic             select,
  output logic             enable,
  output logic [1:0]       state_led
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_RUN = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic             sel_nx;
  logic             en_nx;
  logic             next_press;
  logic             clr_press;

  operand_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .press (next_press)
  );

  operand_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .press (clr_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_A;
      input_a <= '0;
      input_b <= '0;
      select  <= 1'b0;
      enable  <= 1'b0;
    end else begin
      state   <= state_nx;
      input_a <= a_nx;
      input_b <= b_nx;
      select  <= sel_nx;
      enable  <= en_nx;
    end
  end

  // Operands and enable are committed on the same edge, so the datapath never sees enable with stale data.
  always_comb begin
    state_nx = state;
    a_nx     = input_a;
    b_nx     = input_b;
    sel_nx   = select;
    en_nx    = enable;
    case (state)
      S_A: begin
        if (next_press) begin
          a_nx     = sw;
          state_nx = S_B;
        end
      end
      S_B: begin
        if (next_press) begin
          b_nx     = sw;
          sel_nx   = sw_op;
          en_nx    = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (next_press) begin
          en_nx    = 1'b0;
          state_nx = S_A;
`ifdef OPERAND_LOADER_AUTO_CLEAR_EN
          a_nx     = '0;
          b_nx     = '0;
          sel_nx   = 1'b0;
`endif
        end
      end
      default: begin
        a_nx     = '0;
        b_nx     = '0;
        sel_nx   = 1'b0;
        en_nx    = 1'b0;
        state_nx = S_A;
      end
    endcase
    // Clear overrides whatever a simultaneous next press requested.
    if (clr_press) begin
      a_nx     = '0;
      b_nx     = '0;
      sel_nx   = 1'b0;
      en_nx    = 1'b0;
      state_nx = S_A;
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader with DEBOUNCE_CYCLES = 4.
// Expected values follow OPERAND_LOADER_AUTO_CLEAR_EN when it is defined.

module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       sw_op;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] input_a;
  logic [3:0] input_b;
  logic       select;
  logic       enable;
  logic [1:0] state_led;

  int total;
  int bad;

  operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sw_op     (sw_op),
    .btn_next  (btn_next),
    .btn_clr   (btn_clr),
    .input_a   (input_a),
    .input_b   (input_b),
    .select    (select),
    .enable    (enable),
    .state_led (state_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press_next(input int hold);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_clr(input int hold);
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (hold) @(negedge clk);
    btn_clr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw = 4'h0; sw_op = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({input_a, input_b, select, enable, state_led} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_outputs got a=%0d b=%0d sel=%0d en=%0d st=%0d want all zero",
               input_a, input_b, select, enable, state_led);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (state_led !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_release_state got %0d want 0", state_led);
    end
  endtask

  task automatic test_full_sequence;
    sw = 4'd3; sw_op = 1'b0;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (input_a !== 4'd0 || state_led !== 2'b00) begin
      bad++;
      $display("[TB] FAIL a_edge6 got a=%0d st=%0d want a=0 st=0", input_a, state_led);
    end
    @(posedge clk);
    #1;
    total++;
    if (input_a !== 4'd3 || state_led !== 2'b01) begin
      bad++;
      $display("[TB] FAIL a_edge7 got a=%0d st=%0d want a=3 st=1", input_a, state_led);
    end
    @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    sw = 4'd5; sw_op = 1'b1;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (enable !== 1'b0 || state_led !== 2'b01 || input_b !== 4'd0) begin
      bad++;
      $display("[TB] FAIL b_edge6 got b=%0d en=%0d st=%0d want b=0 en=0 st=1", input_b, enable, state_led);
    end
    @(posedge clk);
    #1;
    total++;
    if (input_a !== 4'd3 || input_b !== 4'd5 || select !== 1'b1 || enable !== 1'b1 || state_led !== 2'b10) begin
      bad++;
      $display("[TB] FAIL b_edge7 got a=%0d b=%0d sel=%0d en=%0d st=%0d want 3 5 1 1 2",
               input_a, input_b, select, enable, state_led);
    end
    @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    sw = 4'd12; sw_op = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (input_a !== 4'd3 || input_b !== 4'd5 || select !== 1'b1 || state_led !== 2'b10) begin
      bad++;
      $display("[TB] FAIL switch_stability got a=%0d b=%0d sel=%0d st=%0d want 3 5 1 2",
               input_a, input_b, select, state_led);
    end
  endtask

  task automatic test_run_exit;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic       exp_sel;
`ifdef OPERAND_LOADER_AUTO_CLEAR_EN
    exp_a = 4'd0; exp_b = 4'd0; exp_sel = 1'b0;
`else
    exp_a = 4'd3; exp_b = 4'd5; exp_sel = 1'b1;
`endif
    press_next(8);
    total++;
    if (enable !== 1'b0 || state_led !== 2'b00) begin
      bad++;
      $display("[TB] FAIL run_exit_state got en=%0d st=%0d want en=0 st=0", enable, state_led);
    end
    total++;
    if (input_a !== exp_a || input_b !== exp_b || select !== exp_sel) begin
      bad++;
      $display("[TB] FAIL run_exit_operands got a=%0d b=%0d sel=%0d want a=%0d b=%0d sel=%0d",
               input_a, input_b, select, exp_a, exp_b, exp_sel);
    end
  endtask

  task automatic test_reset_mid_entry;
    sw = 4'd3;
    press_next(8);
    total++;
    if (input_a !== 4'd3 || state_led !== 2'b01) begin
      bad++;
      $display("[TB] FAIL mid_entry_setup got a=%0d st=%0d want a=3 st=1", input_a, state_led);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({input_a, input_b, select, enable, state_led} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL async_reset got a=%0d b=%0d sel=%0d en=%0d st=%0d want all zero",
               input_a, input_b, select, enable, state_led);
    end
    #2 rst_n = 1'b1;
    sw = 4'd7;
    press_next(8);
    total++;
    if (input_a !== 4'd7 || state_led !== 2'b01) begin
      bad++;
      $display("[TB] FAIL after_reset_press got a=%0d st=%0d want a=7 st=1", input_a, state_led);
    end
  endtask

  task automatic test_bounce;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      repeat (2) @(negedge clk);
    end
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (state_led !== 2'b01 || enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bounce_reject got st=%0d en=%0d want st=1 en=0", state_led, enable);
    end
    sw = 4'd2; sw_op = 1'b0;
    press_next(3);
    total++;
    if (state_led !== 2'b01 || enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL short3_reject got st=%0d en=%0d want st=1 en=0", state_led, enable);
    end
    press_next(4);
    total++;
    if (state_led !== 2'b10 || input_a !== 4'd7 || input_b !== 4'd2 || select !== 1'b0 || enable !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clean4_accept got st=%0d a=%0d b=%0d sel=%0d en=%0d want 2 7 2 0 1",
               state_led, input_a, input_b, select, enable);
    end
  endtask

  task automatic test_long_hold;
    press_next(8);
    sw = 4'd9;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (state_led !== 2'b01 || input_a !== 4'd9) begin
      bad++;
      $display("[TB] FAIL long_hold_step got st=%0d a=%0d want st=1 a=9", state_led, input_a);
    end
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (state_led !== 2'b01 || enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL release_no_step got st=%0d en=%0d want st=1 en=0", state_led, enable);
    end
  endtask

  task automatic test_simultaneous;
    press_clr(8);
    total++;
    if (state_led !== 2'b00 || input_a !== 4'd0) begin
      bad++;
      $display("[TB] FAIL clear_press got st=%0d a=%0d want st=0 a=0", state_led, input_a);
    end
    sw = 4'd3;
    press_next(8);
    @(negedge clk);
    btn_next = 1'b1;
    btn_clr  = 1'b1;
    repeat (8) @(negedge clk);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (state_led !== 2'b00 || input_a !== 4'd0 || enable !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_wins got st=%0d a=%0d en=%0d want st=0 a=0 en=0", state_led, input_a, enable);
    end
  endtask

  task automatic test_held_through_reset;
    @(negedge clk);
    btn_next = 1'b1;
    rst_n    = 1'b0;
    sw       = 4'd4;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (state_led !== 2'b00 || input_a !== 4'd0) begin
      bad++;
      $display("[TB] FAIL held_edge6 got st=%0d a=%0d want st=0 a=0", state_led, input_a);
    end
    @(posedge clk);
    #1;
    total++;
    if (state_led !== 2'b01 || input_a !== 4'd4) begin
      bad++;
      $display("[TB] FAIL held_edge7 got st=%0d a=%0d want st=1 a=4", state_led, input_a);
    end
    @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    $display("[TB] operand_loader bench start");
    test_reset();
    test_full_sequence();
    test_run_exit();
    test_reset_mid_entry();
    test_bounce();
    test_long_hold();
    test_simultaneous();
    test_held_through_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
